// File: rtl/dsi_pkt_sched.sv
// Packet-granular round-robin scheduler: drains NUM_SRC fall-through FIFOs into one
// DSI packet stream, holding the grant for a whole packet and enforcing an idle gap.
module dsi_pkt_sched #(
    parameter int DATA_BITS   = 8,
    parameter int NUM_SRC     = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int STALL_LIMIT = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC-1:0]               src_empty,
    input  logic [NUM_SRC*(DATA_BITS+1)-1:0] src_data,
    output logic [NUM_SRC-1:0]               src_oe,
    output logic [DATA_BITS-1:0]             out_data,
    output logic                             out_last,
    output logic [2:0]                       out_src,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             stall_err
);
    localparam int W = DATA_BITS + 1;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_e;

    state_e               state_q, state_d;
    logic [2:0]           grant_q, grant_d;
    logic [2:0]           last_grant_q, last_grant_d;
    logic [7:0]           gap_cnt_q, gap_cnt_d;
    logic [15:0]          stall_cnt_q, stall_cnt_d;
    logic                 stall_err_q, stall_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 last_q, last_d;
    logic                 valid_q, valid_d;
    logic [2:0]           src_q, src_d;

    logic [7:0]           empty_ext;
    logic [7:0]           oe_ext;
    logic [W-1:0]         word_ext [8];
    logic [W-1:0]         cur_word;
    logic                 load;
    logic                 pick_found;
    logic [2:0]           pick_idx;
    logic [3:0]           cand;

    // Pad the per-source views to 8 entries so a 3-bit grant can index them directly.
    for (genvar g = 0; g < 8; g++) begin : g_ext
        if (g < NUM_SRC) begin : g_src
            assign empty_ext[g] = src_empty[g];
            assign word_ext[g]  = src_data[g*W +: W];
        end else begin : g_pad
            assign empty_ext[g] = 1'b1;
            assign word_ext[g]  = '0;
        end
    end

    assign cur_word = word_ext[grant_q];
    assign load     = (state_q == S_XFER) && !empty_ext[grant_q] && (!valid_q || out_ready);

    // Round-robin pick: first non-empty source after last_grant, wrapping at NUM_SRC.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = {1'b0, last_grant_q} + 4'(k);
            if (cand >= 4'(NUM_SRC)) cand = cand - 4'(NUM_SRC);
            if (!pick_found && !empty_ext[cand[2:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[2:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        gap_cnt_d    = gap_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (load) begin
                    stall_cnt_d = '0;
                end else if (empty_ext[grant_q] && stall_cnt_q != 16'(STALL_LIMIT)) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
                if (load && cur_word[W-1]) begin
                    last_grant_d = grant_q;
                    if (GAP_CYCLES > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = 8'(GAP_CYCLES);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q <= 8'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Pulse only on the transition into the saturated count.
        stall_err_d = (stall_cnt_d == 16'(STALL_LIMIT)) && (stall_cnt_q != 16'(STALL_LIMIT));
    end

    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        src_d   = src_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = cur_word[DATA_BITS-1:0];
            last_d  = cur_word[W-1];
            src_d   = grant_q;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        oe_ext          = '0;
        oe_ext[grant_q] = load;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= 3'(NUM_SRC - 1);
            gap_cnt_q    <= '0;
            stall_cnt_q  <= '0;
            stall_err_q  <= 1'b0;
            data_q       <= '0;
            last_q       <= 1'b0;
            src_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            gap_cnt_q    <= gap_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            stall_err_q  <= stall_err_d;
            data_q       <= data_d;
            last_q       <= last_d;
            src_q        <= src_d;
            valid_q      <= valid_d;
        end
    end

    assign src_oe    = oe_ext[NUM_SRC-1:0];
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_src   = src_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != S_IDLE);
    assign stall_err = stall_err_q;

endmodule

// File: tb/tb_dsi_pkt_sched.sv
// Scoreboard bench for dsi_pkt_sched: FIFO source models, expected-word queue and a
// decoupled output monitor; a second instance with no gap checks minimum spacing.
module tb_dsi_pkt_sched;
    localparam int DB   = 8;
    localparam int NS   = 4;
    localparam int GAP  = 4;
    localparam int SLIM = 8;
    localparam int W    = DB + 1;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [2:0] src;
        int         gap;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NS-1:0]   src_empty;
    logic [NS*W-1:0] src_data;
    logic [NS-1:0]   src_oe;
    logic [DB-1:0]   out_data;
    logic            out_last;
    logic [2:0]      out_src;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            busy;
    logic            stall_err;

    logic [NS-1:0]   z_empty;
    logic [NS*W-1:0] z_data;
    logic [NS-1:0]   z_oe;
    logic [DB-1:0]   z_out_data;
    logic            z_out_last;
    logic [2:0]      z_out_src;
    logic            z_valid;
    logic            z_busy;
    logic            z_stall;

    dsi_pkt_sched #(.DATA_BITS(DB), .NUM_SRC(NS), .GAP_CYCLES(GAP), .STALL_LIMIT(SLIM)) u_dut (
        .clk(clk), .rst(rst), .src_empty(src_empty), .src_data(src_data), .src_oe(src_oe),
        .out_data(out_data), .out_last(out_last), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .stall_err(stall_err)
    );

    dsi_pkt_sched #(.DATA_BITS(DB), .NUM_SRC(NS), .GAP_CYCLES(0), .STALL_LIMIT(64)) u_dut_g0 (
        .clk(clk), .rst(rst), .src_empty(z_empty), .src_data(z_data), .src_oe(z_oe),
        .out_data(z_out_data), .out_last(z_out_last), .out_src(z_out_src), .out_valid(z_valid),
        .out_ready(1'b1), .busy(z_busy), .stall_err(z_stall)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Source FIFO models (fall-through: head word visible while non-empty)
    logic [W-1:0] fifo [NS][32];
    int wr_ptr [NS]       = '{default: 0};
    int rd_ptr [NS]       = '{default: 0};
    int pop_cnt [NS]      = '{default: 0};
    int last_pop_cyc [NS] = '{default: 0};
    int last_load_cyc     = 0;
    logic [NS-1:0] oe_s   = '0;

    always_comb begin
        src_empty = '0;
        src_data  = '0;
        for (int i = 0; i < NS; i++) begin
            src_empty[i]       = (rd_ptr[i] == wr_ptr[i]);
            src_data[i*W +: W] = fifo[i][rd_ptr[i][4:0]];
        end
    end

    // Gap-free instance: source 0 only, z_left single-word packets queued.
    int   z_left = 0;
    logic z_oe_s = 1'b0;
    assign z_empty = {3'b111, (z_left == 0)};
    assign z_data  = {27'd0, 1'b1, 8'(z_left)};

    exp_t exp_q [$];
    exp_t mon_e;
    int   z_rise [$];

    task automatic push(input int s, input logic [7:0] d, input logic l);
        fifo[s][wr_ptr[s][4:0]] = {l, d};
        wr_ptr[s]++;
    endtask

    task automatic sb_push(input int s, input logic [7:0] d, input logic l, input int g);
        exp_q.push_back('{data: d, last: l, src: 3'(s), gap: g});
    endtask

    // Pop decisions are sampled at the falling edge and applied at the rising edge.
    always @(negedge clk) begin
        oe_s   = src_oe;
        z_oe_s = z_oe[0];
        if (rst && src_oe != '0) begin
            check("oe_onehot", 32'($countones(src_oe)), 32'd1);
            for (int i = 0; i < NS; i++)
                if (src_oe[i]) check("oe_nonempty", 32'(src_empty[i]), 32'd0);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                if (oe_s[i]) begin
                    rd_ptr[i]       <= rd_ptr[i] + 1;
                    pop_cnt[i]      <= pop_cnt[i] + 1;
                    last_pop_cyc[i] <= cyc;
                    if (fifo[i][rd_ptr[i][4:0]][W-1]) last_load_cyc <= cyc;
                end
            end
            if (z_oe_s) z_left <= z_left - 1;
        end
    end

    // Output monitor
    int         prev_acc_cyc = 0;
    logic       hold_v       = 1'b0;
    logic [7:0] hold_d       = '0;
    int         stall_pulses = 0;
    int         stall_cyc    = 0;
    logic       z_prev       = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            hold_v = 1'b0;
            z_prev = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_d));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(out_data), 32'h100);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(mon_e.data));
                    check("out_last", 32'(out_last), 32'(mon_e.last));
                    check("out_src", 32'(out_src), 32'(mon_e.src));
                    if (mon_e.gap >= 0) check("spacing", 32'(cyc - prev_acc_cyc), 32'(mon_e.gap));
                end
                prev_acc_cyc = cyc;
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            if (stall_err) begin
                stall_pulses++;
                stall_cyc = cyc;
            end
            if (z_valid && !z_prev) z_rise.push_back(cyc);
            z_prev = z_valid;
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < budget && !(busy == 1'b0 && exp_q.size() == 0 && src_empty == '1));
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_sb", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        int sp0;
        int pop_cyc;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_src", 32'(out_src), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall_err), 32'd0);
        check("rst_oe", 32'(src_oe), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Round-robin: all four sources, one 1-word packet each
        @(posedge clk); #1;
        for (int s = 0; s < NS; s++) begin
            push(s, 8'(8'hA0 + s), 1'b1);
            sb_push(s, 8'(8'hA0 + s), 1'b1, (s == 0) ? -1 : GAP + 2);
        end
        wait_idle(200);

        // Refill sources 3 and 0 only: 0 wins after last grant 3
        @(posedge clk); #1;
        push(3, 8'hB3, 1'b1);
        push(0, 8'hB0, 1'b1);
        sb_push(0, 8'hB0, 1'b1, -1);
        sb_push(3, 8'hB3, 1'b1, GAP + 2);
        wait_idle(100);

        // Single source, three consecutive words, busy falls GAP+1 after last load
        @(posedge clk); #1;
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h33, 1'b1);
        sb_push(2, 8'h11, 1'b0, -1);
        sb_push(2, 8'h22, 1'b0, 1);
        sb_push(2, 8'h33, 1'b1, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 60 && !(exp_q.size() == 0 && !busy));
        check("busy_fall", 32'(cyc - last_load_cyc), 32'(GAP + 1));
        wait_idle(50);

        // Backpressure: out_ready low every other cycle
        p0 = pop_cnt[1];
        @(posedge clk); #1;
        out_ready = 1'b0;
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b0);
        push(1, 8'h44, 1'b1);
        for (int k = 0; k < 4; k++) sb_push(1, 8'(8'h41 + k), (k == 3), -1);
        n = 0;
        while (n < 60 && exp_q.size() != 0) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
            n++;
        end
        out_ready = 1'b1;
        wait_idle(50);
        check("bp_pops", 32'(pop_cnt[1] - p0), 32'd4);

        // Starvation: source 1 sends one word then runs dry for 20 cycles
        sp0 = stall_pulses;
        @(posedge clk); #1;
        push(1, 8'h51, 1'b0);
        sb_push(1, 8'h51, 1'b0, -1);
        repeat (3) @(posedge clk);
        pop_cyc = last_pop_cyc[1];
        #1;
        push(0, 8'h60, 1'b1);
        repeat (18) @(posedge clk);
        #1;
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_no_pop0", 32'(src_empty[0]), 32'd0);
        push(1, 8'h52, 1'b1);
        sb_push(1, 8'h52, 1'b1, -1);
        sb_push(0, 8'h60, 1'b1, GAP + 2);
        wait_idle(100);
        check("stall_pulses", 32'(stall_pulses - sp0), 32'd1);
        check("stall_time", 32'(stall_cyc - pop_cyc), 32'(SLIM + 1));

        // Back-to-back single-word packets from one source
        @(posedge clk); #1;
        push(3, 8'h71, 1'b1);
        push(3, 8'h72, 1'b1);
        sb_push(3, 8'h71, 1'b1, -1);
        sb_push(3, 8'h72, 1'b1, GAP + 2);
        wait_idle(100);

        // Gap-free instance: spacing between out_valid rises is 2
        z_rise.delete();
        @(posedge clk); #1;
        z_left = 2;
        repeat (12) @(negedge clk);
        check("g0_rises", 32'(z_rise.size()), 32'd2);
        if (z_rise.size() == 2) check("g0_spacing", 32'(z_rise[1] - z_rise[0]), 32'd2);
        check("g0_drained", 32'(z_left), 32'd0);

        // Async reset during word 2 of a 4-word packet
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) push(2, 8'(8'h81 + k), (k == 3));
        sb_push(2, 8'h81, 1'b0, -1);
        sb_push(2, 8'h82, 1'b0, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 20 && !(out_valid && out_data == 8'h82));
        check("ar_word2_seen", 32'(out_data), 32'h82);
        #1;
        rst = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_data", 32'(out_data), 32'd0);
        check("ar_last", 32'(out_last), 32'd0);
        check("ar_src", 32'(out_src), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_oe", 32'(src_oe), 32'd0);
        check("ar_stall", 32'(stall_err), 32'd0);
        exp_q.delete();
        push(3, 8'h93, 1'b1);
        push(1, 8'h91, 1'b1);
        sb_push(1, 8'h91, 1'b1, -1);
        sb_push(2, 8'h83, 1'b0, GAP + 2);
        sb_push(2, 8'h84, 1'b1, 1);
        sb_push(3, 8'h93, 1'b1, GAP + 2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_idle(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
